psm_result_serializer: RTL and testbench



---
 rtl/psm_result_serializer_pkg.sv | 37 +++
 rtl/psm_result_serializer_if.sv | 25 ++
 rtl/psm_result_serializer_trit_check.sv | 18 +
 rtl/psm_result_serializer.sv | 179 +++++++++++++++++
 tb/tb_psm_result_serializer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psm_result_serializer_pkg.sv
// Shared constants, state encoding and header packing for the result serializer.
// Header layout: bit0 zero, bit1 trit error, bit2 overflow, bits[15:8] frame counter.
package psm_result_serializer_pkg;

    localparam int DATA_W_DEF   = 194;
    localparam int OUT_W_DEF    = 32;
    localparam int HDR_ZERO_BIT = 0;
    localparam int HDR_TERR_BIT = 1;
    localparam int HDR_OVF_BIT  = 2;
    localparam int HDR_CNT_LSB  = 8;
    localparam int CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XS   = 2'd2,
        ST_YS   = 2'd3
    } ser_state_t;

    function automatic int words_for(input int data_w, input int out_w);
        return (data_w + out_w - 1) / out_w;
    endfunction

    function automatic logic [15:0] make_header(input logic zero,
                                                input logic terr,
                                                input logic ovf,
                                                input logic [CNT_W-1:0] cnt);
        logic [15:0] h;
        h = '0;
        h[HDR_ZERO_BIT]            = zero;
        h[HDR_TERR_BIT]            = terr;
        h[HDR_OVF_BIT]             = ovf;
        h[HDR_CNT_LSB +: CNT_W]    = cnt;
        return h;
    endfunction

endpackage

// File: rtl/psm_result_serializer_if.sv
// Valid/ready word stream carrying serialized point results toward the host link.
interface psm_result_serializer_if #(
    parameter int OUT_W = 32
) ();

    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/psm_result_serializer_trit_check.sv
// Flags any 2-bit GF(3) digit encoded as 2'b11 within a coordinate.
module psm_result_serializer_trit_check #(
    parameter int DATA_W = 194
) (
    input  logic [DATA_W-1:0] coord,
    output logic              bad
);

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DATA_W / 2; i++) begin
            if (coord[2*i +: 2] == 2'b11) begin
                bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psm_result_serializer.sv
// Captures a point_scalar_mult result on the rising edge of done and streams it as framed words.
// Optional macro PSM_SER_TRIT_CHECK_EN enables the invalid-trit flag in header bit1.
module psm_result_serializer
    import psm_result_serializer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     done,
    input  logic [DATA_W-1:0]        x3,
    input  logic [DATA_W-1:0]        y3,
    input  logic                     zero3,
    psm_result_serializer_if.master  stream,
    output logic                     busy
);

    localparam int WORDS    = words_for(DATA_W, OUT_W);
    localparam int IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PAD_W    = WORDS * OUT_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    ser_state_t        state, state_n;
    logic [IDX_W-1:0]  idx, idx_n, idx_inc;
    logic [OUT_W-1:0]  data_n;
    logic              valid_n, last_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              ovf, ovf_n;
    logic              done_q;
    logic [DATA_W-1:0] x_reg, y_reg;
    logic              zero_reg;
    logic              terr;
    logic              rise, xfer, final_xfer, capture, drop, idx_last;

    function automatic logic [OUT_W-1:0] pick(input logic [DATA_W-1:0] c,
                                              input logic [IDX_W-1:0]  k);
        logic [PAD_W-1:0] p;
        p = '0;
        p[DATA_W-1:0] = c;
        return p[k*OUT_W +: OUT_W];
    endfunction

`ifdef PSM_SER_TRIT_CHECK_EN
    logic bad_x, bad_y;

    psm_result_serializer_trit_check #(.DATA_W(DATA_W)) u_chk_x (
        .coord (x3),
        .bad   (bad_x)
    );

    psm_result_serializer_trit_check #(.DATA_W(DATA_W)) u_chk_y (
        .coord (y3),
        .bad   (bad_y)
    );

    assign terr = !zero3 && (bad_x || bad_y);
`else
    assign terr = 1'b0;
`endif

    assign rise       = done && !done_q;
    assign xfer       = stream.out_valid && stream.out_ready;
    assign final_xfer = xfer && stream.out_last;
    // A new result may only start a frame when the link is idle or the last word is leaving now.
    assign capture    = rise && ((state == ST_IDLE) || final_xfer);
    assign drop       = rise && !capture;
    assign idx_inc    = idx + 1'b1;
    assign idx_last   = (idx == IDX_LAST);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = stream.out_data;
        valid_n = stream.out_valid;
        last_n  = stream.out_last;
        cnt_n   = cnt;
        ovf_n   = ovf;

        if (xfer && (state == ST_HDR)) begin
            cnt_n = cnt + 1'b1;
            if (stream.out_data[HDR_OVF_BIT]) begin
                ovf_n = 1'b0;
            end
        end
        if (drop) begin
            ovf_n = 1'b1;
        end

        case (state)
            ST_HDR: begin
                if (xfer) begin
                    if (zero_reg) begin
                        state_n = ST_IDLE;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        data_n  = '0;
                    end else begin
                        state_n = ST_XS;
                        idx_n   = '0;
                        data_n  = pick(x_reg, '0);
                        last_n  = 1'b0;
                    end
                end
            end
            ST_XS: begin
                if (xfer) begin
                    if (idx_last) begin
                        state_n = ST_YS;
                        idx_n   = '0;
                        data_n  = pick(y_reg, '0);
                        last_n  = (WORDS == 1);
                    end else begin
                        idx_n   = idx_inc;
                        data_n  = pick(x_reg, idx_inc);
                    end
                end
            end
            ST_YS: begin
                if (xfer) begin
                    if (idx_last) begin
                        state_n = ST_IDLE;
                        idx_n   = '0;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        data_n  = '0;
                    end else begin
                        idx_n   = idx_inc;
                        data_n  = pick(y_reg, idx_inc);
                        last_n  = (idx_inc == IDX_LAST);
                    end
                end
            end
            default: begin
            end
        endcase

        // Header uses post-update counter/flag so back-to-back frames see this cycle's header transfer.
        if (capture) begin
            state_n = ST_HDR;
            idx_n   = '0;
            valid_n = 1'b1;
            last_n  = zero3;
            data_n  = OUT_W'(make_header(zero3, terr, ovf_n, cnt_n));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            idx              <= '0;
            stream.out_data  <= '0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            cnt              <= '0;
            ovf              <= 1'b0;
            done_q           <= 1'b1;
            x_reg            <= '0;
            y_reg            <= '0;
            zero_reg         <= 1'b0;
        end else begin
            state            <= state_n;
            idx              <= idx_n;
            stream.out_data  <= data_n;
            stream.out_valid <= valid_n;
            stream.out_last  <= last_n;
            cnt              <= cnt_n;
            ovf              <= ovf_n;
            done_q           <= done;
            if (capture) begin
                x_reg    <= x3;
                y_reg    <= y3;
                zero_reg <= zero3;
            end
        end
    end

endmodule

// File: tb/tb_psm_result_serializer.sv
// Self-checking bench: queue-based frame model compared every cycle, plus directed literal checks.
module tb_psm_result_serializer;

    localparam int DATA_W = 194;
    localparam int OUT_W  = 32;
    localparam int WORDS  = 7;

    localparam logic [DATA_W-1:0] PX = 194'h2a4290286121261a82446a41200622024988295015114486;
    localparam logic [DATA_W-1:0] PY = 194'h29a0856124a9026518a0412956a8021459a0612584a91;

    logic              clk = 1'b0;
    logic              reset;
    logic              done;
    logic              zero3;
    logic [DATA_W-1:0] x3, y3;
    logic              busy;

    psm_result_serializer_if #(.OUT_W(OUT_W)) sif ();

    psm_result_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .done   (done),
        .x3     (x3),
        .y3     (y3),
        .zero3  (zero3),
        .stream (sif),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [OUT_W-1:0] pend[$];
    bit               pend_hdr;
    bit               m_done_q;
    int               m_cnt;
    bit               m_ovf;
    logic [OUT_W-1:0] got_data[$];
    bit               got_last[$];

    bit               mv, mx, mfin, mrise, mcap, mdrop, mterr;
    logic [OUT_W-1:0] mhdr;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] coord_word(input logic [DATA_W-1:0] c, input int k);
        logic [DATA_W-1:0] s;
        s = c >> (OUT_W * k);
        return s[OUT_W-1:0];
    endfunction

    function automatic bit has_bad(input logic [DATA_W-1:0] c);
        for (int i = 0; i < DATA_W / 2; i++) begin
            if (c[2*i +: 2] == 2'b11) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] rand_coord(input bit valid_only);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) r = (r << 32) | DATA_W'($urandom);
        if (valid_only) begin
            for (int i = 0; i < DATA_W / 2; i++) begin
                if (r[2*i +: 2] == 2'b11) r[2*i+1] = 1'b0;
            end
        end
        return r;
    endfunction

    // Model: a frame is the list of words still owed; the head is what the DUT must present.
    always @(negedge clk) begin
        if (reset) begin
            pend.delete();
            pend_hdr = 1'b0;
            m_cnt    = 0;
            m_ovf    = 1'b0;
            m_done_q = 1'b1;
            checkOutput("reset_valid", sif.out_valid, 1'b0);
            checkOutput("reset_busy", busy, 1'b0);
        end else begin
            mv = (pend.size() > 0);
            checkOutput("out_valid", sif.out_valid, mv);
            checkOutput("busy", busy, mv);
            if (mv) begin
                checkOutput("out_data", sif.out_data, pend[0]);
                checkOutput("out_last", sif.out_last, pend.size() == 1);
            end
            if (sif.out_valid && sif.out_ready) begin
                got_data.push_back(sif.out_data);
                got_last.push_back(sif.out_last);
            end

            mx    = mv && sif.out_ready;
            mfin  = mx && (pend.size() == 1);
            mrise = done && !m_done_q;
            mcap  = mrise && (!mv || mfin);
            mdrop = mrise && !mcap;
            if (mx) begin
                if (pend_hdr) begin
                    m_cnt = (m_cnt + 1) % 256;
                    if (pend[0][2]) m_ovf = 1'b0;
                end
                void'(pend.pop_front());
                pend_hdr = 1'b0;
            end
            if (mdrop) m_ovf = 1'b1;
            if (mcap) begin
`ifdef PSM_SER_TRIT_CHECK_EN
                mterr = !zero3 && (has_bad(x3) || has_bad(y3));
`else
                mterr = 1'b0;
`endif
                mhdr = 32'(zero3) | (32'(mterr) << 1) | (32'(m_ovf) << 2) | (32'(m_cnt) << 8);
                pend.push_back(mhdr);
                pend_hdr = 1'b1;
                if (!zero3) begin
                    for (int k = 0; k < WORDS; k++) pend.push_back(coord_word(x3, k));
                    for (int k = 0; k < WORDS; k++) pend.push_back(coord_word(y3, k));
                end
            end
            m_done_q = done;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic d, input logic z,
                                 input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                 input logic rdy);
        done          = d;
        zero3         = z;
        x3            = x;
        y3            = y;
        sif.out_ready = rdy;
    endtask

    task automatic waitIdle(input int budget);
        int c;
        c = 0;
        while (pend.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        if (pend.size() != 0) checkOutput("frame_timeout", 1, 0);
    endtask

    logic [OUT_W-1:0] xexp [7];
    int base, nlast, c;

    initial begin
        xexp = '{32'h15114486, 32'h49882950, 32'h20062202, 32'h82446a41,
                 32'h6121261a, 32'h2a429028, 32'h00000000};
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        tick(3);
        reset = 1'b0;
        tick(2);
        checkOutput("rst_out_valid", sif.out_valid, 1'b0);
        checkOutput("rst_out_data", sif.out_data, 32'h0);
        checkOutput("rst_out_last", sif.out_last, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);

        // Zero result: single header word.
        base = got_data.size();
        applyStimulus(1'b1, 1'b1, '0, '0, 1'b1);
        tick(1);
        checkOutput("zero_latency_valid", sif.out_valid, 1'b1);
        checkOutput("zero_hdr_data", sif.out_data, 32'h00000001);
        checkOutput("zero_hdr_last", sif.out_last, 1'b1);
        waitIdle(50);
        done = 1'b0;
        tick(2);
        checkOutput("zero_frame_len", got_data.size() - base, 1);

        // Point result: 15 words, counter now 1.
        base = got_data.size();
        applyStimulus(1'b1, 1'b0, PX, PY, 1'b1);
        tick(1);
        waitIdle(100);
        done = 1'b0;
        tick(2);
        checkOutput("point_frame_len", got_data.size() - base, 15);
        checkOutput("point_hdr", got_data[base], 32'h00000100);
        for (int k = 0; k < 7; k++) checkOutput("point_xword", got_data[base+1+k], xexp[k]);
        nlast = 0;
        for (int k = 0; k < 15; k++) nlast += got_last[base+k];
        checkOutput("point_last_count", nlast, 1);
        checkOutput("point_last_pos", got_last[base+14], 1'b1);

        // Backpressure: random stalls, still exactly 15 transfers.
        base = got_data.size();
        applyStimulus(1'b1, 1'b0, PX, PY, 1'b0);
        tick(1);
        c = 0;
        while (pend.size() != 0 && c < 400) begin
            sif.out_ready = $urandom_range(0, 1);
            tick(1);
            c++;
        end
        if (pend.size() != 0) checkOutput("bp_timeout", 1, 0);
        sif.out_ready = 1'b1;
        done = 1'b0;
        tick(2);
        checkOutput("bp_frame_len", got_data.size() - base, 15);
        checkOutput("bp_hdr", got_data[base], 32'h00000200);

        // Overflow: drop during x words, flag shows on next header only.
        base = got_data.size();
        applyStimulus(1'b1, 1'b0, PX, PY, 1'b1);
        tick(4);
        done = 1'b0;
        tick(1);
        done = 1'b1;
        tick(1);
        waitIdle(100);
        done = 1'b0;
        tick(1);
        done = 1'b1;
        tick(1);
        waitIdle(100);
        done = 1'b0;
        tick(1);
        done = 1'b1;
        tick(1);
        waitIdle(100);
        done = 1'b0;
        tick(2);
        checkOutput("ovf_total_len", got_data.size() - base, 45);
        checkOutput("ovf_hdr1", got_data[base], 32'h00000300);
        checkOutput("ovf_frame1_x0", got_data[base+1], 32'h15114486);
        checkOutput("ovf_hdr2", got_data[base+15], 32'h00000404);
        checkOutput("ovf_hdr3", got_data[base+30], 32'h00000500);

        // Reset mid-frame at y word 3.
        base = got_data.size();
        applyStimulus(1'b1, 1'b0, PX, PY, 1'b1);
        c = 0;
        while (got_data.size() < base + 11 && c < 100) begin
            tick(1);
            c++;
        end
        checkOutput("rstmid_reach", got_data.size() - base, 11);
        reset = 1'b1;
        #1;
        checkOutput("rstmid_valid", sif.out_valid, 1'b0);
        checkOutput("rstmid_busy", busy, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(20);
        checkOutput("rstmid_no_frame", got_data.size() - base, 11);
        done = 1'b0;
        tick(1);
        base = got_data.size();
        done = 1'b1;
        tick(1);
        waitIdle(100);
        done = 1'b0;
        tick(2);
        checkOutput("rstmid_new_hdr", got_data[base], 32'h00000000);

        // Trit check on header bit1.
        base = got_data.size();
        applyStimulus(1'b1, 1'b0, 194'h3, '0, 1'b1);
        tick(1);
        waitIdle(100);
        done = 1'b0;
        tick(1);
        applyStimulus(1'b1, 1'b1, 194'h3, '0, 1'b1);
        tick(1);
        waitIdle(100);
        done = 1'b0;
        tick(2);
`ifdef PSM_SER_TRIT_CHECK_EN
        checkOutput("terr_nonzero", got_data[base][1], 1'b1);
`else
        checkOutput("terr_nonzero", got_data[base][1], 1'b0);
`endif
        checkOutput("terr_zero", got_data[base+15][1], 1'b0);
        checkOutput("terr_zero_hdr", got_data[base+15], 32'h00000201);

        // Randomized traffic, backpressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            sif.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) done = ~done;
            if ($urandom_range(0, 7) == 0) begin
                x3    = rand_coord($urandom_range(0, 1) == 1);
                y3    = rand_coord($urandom_range(0, 1) == 1);
                zero3 = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
            tick(1);
        end
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
